// File: rtl/dout_display.sv
// Consumer of the SoC dout/dval bus: edge-captures bytes into a FIFO, converts with
// a sequential double-dabble and shows them on four active-low 7-segment digits.
// Optional build macro: SIGNED_DISPLAY_EN (two's complement display with minus sign on hex3).
module dout_display #(
  parameter int FIFO_DEPTH = 4,
  parameter int HOLD_CNT   = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       dval,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic       busy,
  output logic       overflow
);

  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int HOLD_LOAD = (HOLD_CNT < 1) ? 1 : HOLD_CNT;
  localparam int HW        = $clog2(HOLD_LOAD + 1);
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  typedef enum logic [1:0] {IDLE, CONVERT, DRIVE, SHOW} state_t;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  logic          dval_q;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, capture, pop, push;
  state_t        state;
  logic [19:0]   shift_reg;
  logic [11:0]   bcd_adj;
  logic [19:0]   adj_full;
  logic [2:0]    bit_cnt;
  logic [HW-1:0] hold_cnt;
  logic          neg_reg;
  logic [7:0]    pop_byte, pop_mag;
  logic          pop_neg;

  assign capture = dval && !dval_q;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = (state == IDLE) && !empty;
  // A full FIFO still accepts the byte when a slot frees up in the same cycle.
  assign push    = capture && (!full || pop);
  assign busy    = (state != IDLE) || !empty;

  assign pop_byte = fifo_mem[rd_ptr[AW-1:0]];
`ifdef SIGNED_DISPLAY_EN
  assign pop_neg = pop_byte[7];
  assign pop_mag = pop_byte[7] ? (~pop_byte + 8'd1) : pop_byte;
`else
  assign pop_neg = 1'b0;
  assign pop_mag = pop_byte;
`endif

  // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (shift_reg[8 + gi*4 +: 4] >= 4'd5) ?
                                  shift_reg[8 + gi*4 +: 4] + 4'd3 :
                                  shift_reg[8 + gi*4 +: 4];
    end
  endgenerate
  assign adj_full = {bcd_adj, shift_reg[7:0]};

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dval_q   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      dval_q <= dval;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (capture && full && !pop)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      hold_cnt  <= '0;
      neg_reg   <= 1'b0;
      hex0      <= SEG_BLANK;
      hex1      <= SEG_BLANK;
      hex2      <= SEG_BLANK;
      hex3      <= SEG_BLANK;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shift_reg <= {12'd0, pop_mag};
            neg_reg   <= pop_neg;
            bit_cnt   <= '0;
            state     <= CONVERT;
          end
        end
        CONVERT: begin
          shift_reg <= adj_full << 1;
          bit_cnt   <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7)
            state <= DRIVE;
        end
        DRIVE: begin
          // Leading zeros of hundreds/tens are blanked; ones always shown.
          hex0     <= seg7(shift_reg[11:8]);
          hex1     <= (shift_reg[19:16] == 4'd0 && shift_reg[15:12] == 4'd0) ?
                      SEG_BLANK : seg7(shift_reg[15:12]);
          hex2     <= (shift_reg[19:16] == 4'd0) ? SEG_BLANK : seg7(shift_reg[19:16]);
          hex3     <= neg_reg ? SEG_MINUS : SEG_BLANK;
          hold_cnt <= HW'(HOLD_LOAD);
          state    <= SHOW;
        end
        SHOW: begin
          hold_cnt <= hold_cnt - 1'b1;
          if (hold_cnt == HW'(1))
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dout_display.sv
// Directed bench for dout_display with FIFO_DEPTH=4, HOLD_CNT=4; expected
// segment codes are hand-computed constants.
module tb_dout_display;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic       dval;
  logic [6:0] hex0, hex1, hex2, hex3;
  logic       busy, overflow;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int base;
  logic [6:0] last_h0;
  logic [6:0] seq_exp [5];

  dout_display #(.FIFO_DEPTH(4), .HOLD_CNT(4)) dut (
    .clk(clk), .reset(reset), .din(din), .dval(dval),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else
      $display("ok   %s: 0x%0h", tag, got);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // One-cycle dval pulse, then check latency, digits and hold duration.
  task automatic send_check(input string tag, input logic [7:0] v,
                            input logic [6:0] e0, input logic [6:0] e1,
                            input logic [6:0] e2, input logic [6:0] e3);
    @(negedge clk); din = v; dval = 1'b1;
    @(negedge clk); dval = 1'b0; din = 8'h00;
    repeat (9) @(negedge clk);
    check_eq({tag, "_hex0_early"}, hex0, last_h0);
    @(negedge clk);
    check_eq({tag, "_hex0"}, hex0, e0);
    check_eq({tag, "_hex1"}, hex1, e1);
    check_eq({tag, "_hex2"}, hex2, e2);
    check_eq({tag, "_hex3"}, hex3, e3);
    last_h0 = e0;
    repeat (3) @(negedge clk);
    check_eq({tag, "_busy_hold"}, busy, 1'b1);
    @(negedge clk);
    check_eq({tag, "_busy_end"}, busy, 1'b0);
  endtask

  initial begin
    seq_exp[0] = 7'h79; seq_exp[1] = 7'h24; seq_exp[2] = 7'h30;
    seq_exp[3] = 7'h19; seq_exp[4] = 7'h12;
    reset = 1'b1; dval = 1'b0; din = 8'h00; last_h0 = 7'h7F;
    repeat (2) @(negedge clk);
    check_eq("rst_hex0", hex0, 7'h7F);
    check_eq("rst_hex3", hex3, 7'h7F);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_ovf", overflow, 1'b0);
    reset = 1'b0;

    send_check("d5",   8'd5,   7'h12, 7'h7F, 7'h7F, 7'h7F);
    send_check("d173", 8'd173, 7'h30, 7'h78, 7'h79, 7'h7F);

    // dval held high while din changes: only the first byte is captured.
    @(negedge clk); din = 8'd1; dval = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 6)  din = 8'd2;
      if (i == 12) din = 8'd3;
      if (i == 11) check_eq("held_hex0", hex0, 7'h79);
      if (i == 15) check_eq("held_busy", busy, 1'b0);
    end
    dval = 1'b0;
    repeat (15) @(negedge clk);
    check_eq("held_hex0_after", hex0, 7'h79);
    check_eq("held_busy_after", busy, 1'b0);
    last_h0 = 7'h79;

    send_check("d0", 8'd0, 7'h40, 7'h7F, 7'h7F, 7'h7F);

    // Six pulses back-to-back: 1 pops at once, 2..5 queue, 6 is dropped.
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk); din = 8'(k); dval = 1'b1;
      @(negedge clk); dval = 1'b0;
      if (k == 1) base = cyc;
    end
    check_eq("ovf_set", overflow, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) begin
        wait_to(base + 10 + 14*(k-1) - 1);
        check_eq($sformatf("seq%0d_early", k), hex0, seq_exp[k-2]);
      end
      wait_to(base + 10 + 14*(k-1));
      check_eq($sformatf("seq%0d", k), hex0, seq_exp[k-1]);
    end
    wait_to(base + 69);
    check_eq("seq_busy_hold", busy, 1'b1);
    wait_to(base + 70);
    check_eq("seq_busy_end", busy, 1'b0);
    check_eq("ovf_sticky", overflow, 1'b1);
    last_h0 = 7'h12;

    // Reset in the middle of a conversion.
    @(negedge clk); din = 8'd9; dval = 1'b1;
    @(negedge clk); dval = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("mid_rst_hex0", hex0, 7'h7F);
    check_eq("mid_rst_hex2", hex2, 7'h7F);
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_ovf", overflow, 1'b0);
    @(negedge clk); reset = 1'b0;
    last_h0 = 7'h7F;
    send_check("post_rst_d5", 8'd5, 7'h12, 7'h7F, 7'h7F, 7'h7F);

`ifdef SIGNED_DISPLAY_EN
    send_check("dFF", 8'hFF, 7'h79, 7'h7F, 7'h7F, 7'h3F);
    send_check("d80", 8'h80, 7'h00, 7'h24, 7'h79, 7'h3F);
`else
    send_check("dFF", 8'hFF, 7'h12, 7'h12, 7'h24, 7'h7F);
    send_check("d80", 8'h80, 7'h00, 7'h24, 7'h79, 7'h7F);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
